// File: rtl/scoreboard_hazard_unit.sv
// Hazard detection and forwarding-slot select for the in-order RV32E pipeline.
// Tracks in-flight register writes in a shift-register scoreboard (slot 0 = EX,
// slot PIPE_DEPTH-1 = WB), each entry carrying the first slot its result can be
// forwarded from.
// Ports: clk, rst (async, active-high); ID-stage operands id_* and flush in;
// stall/issue to IF/ID and per-source rsN_fwd_en/rsN_fwd_slot to the operand
// muxes out.
// Optional: define HAZARD_PERF_EN to add the saturating stall_cycles and
// load_use_stalls counters.
module scoreboard_hazard_unit #(
  parameter int PIPE_DEPTH  = 4,
  parameter int REG_IDX_W   = 4,
  parameter int ALU_RDY     = 0,
  parameter int LOAD_RDY    = 3,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [REG_IDX_W-1:0]          id_rs1,
  input  logic [REG_IDX_W-1:0]          id_rs2,
  input  logic                          id_rs1_used,
  input  logic                          id_rs2_used,
  input  logic [REG_IDX_W-1:0]          id_rd,
  input  logic                          id_rd_we,
  input  logic                          id_is_load,
  input  logic                          flush,
  output logic                          stall,
  output logic                          issue,
`ifdef HAZARD_PERF_EN
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   load_use_stalls,
`endif
  output logic                          rs1_fwd_en,
  output logic                          rs2_fwd_en,
  output logic [$clog2(PIPE_DEPTH)-1:0] rs1_fwd_slot,
  output logic [$clog2(PIPE_DEPTH)-1:0] rs2_fwd_slot
);

  localparam int SLOT_W = $clog2(PIPE_DEPTH);

  if (ALU_RDY >= PIPE_DEPTH || LOAD_RDY >= PIPE_DEPTH) begin : g_cfg_err
    $error("scoreboard_hazard_unit: ready slot beyond pipeline depth");
  end

  logic [PIPE_DEPTH-1:0]                valid_q, valid_d;
  logic [PIPE_DEPTH-1:0][REG_IDX_W-1:0] rd_q, rd_d;
  logic [PIPE_DEPTH-1:0][SLOT_W-1:0]    rdy_q, rdy_d;

  logic              hit1, hit2;
  logic              haz1, haz2;
  logic [SLOT_W-1:0] s1, s2;

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    s1   = '0;
    s2   = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && rd_q[k] == id_rs1 && id_rs1 != '0) begin
        hit1 = 1'b1;
        s1   = SLOT_W'(k);
      end
      if (valid_q[k] && rd_q[k] == id_rs2 && id_rs2 != '0) begin
        hit2 = 1'b1;
        s2   = SLOT_W'(k);
      end
    end
  end

  assign haz1 = hit1 && (s1 < rdy_q[s1]);
  assign haz2 = hit2 && (s2 < rdy_q[s2]);

  assign stall = id_valid && !flush &&
                 ((id_rs1_used && haz1) || (id_rs2_used && haz2));
  assign issue = id_valid && !stall && !flush;

  assign rs1_fwd_en   = hit1 && !haz1;
  assign rs2_fwd_en   = hit2 && !haz2;
  assign rs1_fwd_slot = rs1_fwd_en ? s1 : '0;
  assign rs2_fwd_slot = rs2_fwd_en ? s2 : '0;

  // Flushed young slots are dropped instead of advancing; WB simply retires.
  always_comb begin
    valid_d    = '0;
    rd_d       = rd_q;
    rdy_d      = rdy_q;
    valid_d[0] = issue && id_rd_we && (id_rd != '0);
    rd_d[0]    = id_rd;
    rdy_d[0]   = id_is_load ? SLOT_W'(LOAD_RDY) : SLOT_W'(ALU_RDY);
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      valid_d[k] = valid_q[k-1] && !(flush && (k - 1 < FLUSH_SLOTS));
      rd_d[k]    = rd_q[k-1];
      rdy_d[k]   = rdy_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rd_q    <= '0;
      rdy_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PIPE_DEPTH-1:0] load_q, load_d;
  logic [31:0]           stall_cycles_q, stall_cycles_d;
  logic [31:0]           load_use_q, load_use_d;
  logic                  load_block;

  always_comb begin
    load_d    = load_q << 1;
    load_d[0] = id_is_load;
  end

  assign load_block = (id_rs1_used && haz1 && load_q[s1]) ||
                      (id_rs2_used && haz2 && load_q[s2]);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    load_use_d     = load_use_q;
    if (stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (stall && load_block && load_use_q != 32'hFFFF_FFFF)
      load_use_d = load_use_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q         <= '0;
      stall_cycles_q <= '0;
      load_use_q     <= '0;
    end else begin
      load_q         <= load_d;
      stall_cycles_q <= stall_cycles_d;
      load_use_q     <= load_use_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_stalls = load_use_q;
`endif

endmodule
